// File: rtl/scd_pkg.sv
// Shared constants and types for the instruction sequencer.
package scd_pkg;

  localparam int unsigned INST_W = 16;
  localparam int unsigned FLAG_W = 16;
  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 12;

  // Control flag bit positions in ctrl_flags; bits 8..15 belong to the datapath.
  localparam int unsigned LD  = 0;
  localparam int unsigned MR  = 1;
  localparam int unsigned MW  = 2;
  localparam int unsigned SPC = 3;
  localparam int unsigned WPC = 4;
  localparam int unsigned JI  = 5;
  localparam int unsigned IMM = 6;
  localparam int unsigned BR  = 7;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    MEM    = 2'd2,
    WB     = 2'd3
  } state_e;

  // Flags the sequencer still needs after DECODE.
  typedef struct packed {
    logic mw;
    logic spc;
    logic wpc;
    logic ji;
    logic br;
  } seq_flags_t;

endpackage

// File: rtl/inst_seq_if.sv
// Instruction- and data-memory handshake bundle between sequencer and memories.
interface inst_seq_if #(
  parameter int unsigned PC_W = 8
);
  import scd_pkg::*;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic              dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, imem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, imem_rdata, dmem_ack
  );
endinterface

// File: rtl/inst_seq_pc.sv
// Program counter register with pc+1 / target select; increment wraps at 2^PC_W.
module inst_seq_pc #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            upd,
  input  logic            take,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_inc_c
);

  assign pc_inc_c = pc + PC_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pc <= PC_W'(RESET_PC);
    else if (upd) pc <= take ? target : pc_inc_c;
  end

endmodule

// File: rtl/inst_seq.sv
// Multi-cycle FETCH/DECODE/MEM/WB sequencer driving the opcode decode ROM.
// Optional retire counter output enabled by INST_SEQ_RETIRE_CNT_EN.
module inst_seq
  import scd_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  inst_seq_if.master         bus,
  output logic [INST_W-1:0]  inst,
  output logic [3:0]         opcode,
  input  logic [FLAG_W-1:0]  ctrl_flags,
  input  logic               cond,
  input  logic [PC_W-1:0]    pc_target,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    link,
  output logic               reg_we,
`ifdef INST_SEQ_RETIRE_CNT_EN
  output logic [31:0]        retire_cnt,
`endif
  output logic               retire
);

  state_e            state_q, state_d;
  seq_flags_t        flags_q, flags_d, dec_c, fl_c;
  logic [INST_W-1:0] inst_d;
  logic [PC_W-1:0]   link_d, pc_inc_c;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic              reg_we_d, retire_d;
  logic              pc_upd_c, pc_take_c;
  logic              unused_flags;

  assign dec_c        = '{mw: ctrl_flags[MW], spc: ctrl_flags[SPC], wpc: ctrl_flags[WPC],
                          ji: ctrl_flags[JI], br: ctrl_flags[BR]};
  assign fl_c         = (state_q == DECODE) ? dec_c : flags_q;
  assign unused_flags = ^{ctrl_flags[15:8], ctrl_flags[LD], ctrl_flags[IMM]};

  assign opcode        = inst[OPC_HI:OPC_LO];
  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = pc;
  assign bus.dmem_req  = dmem_req_q;
  assign bus.dmem_we   = dmem_we_q;

  inst_seq_pc #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .upd      (pc_upd_c),
    .take     (pc_take_c),
    .target   (pc_target),
    .pc       (pc),
    .pc_inc_c (pc_inc_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      flags_q    <= '0;
      inst       <= '0;
      link       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      reg_we     <= 1'b0;
      retire     <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      inst       <= inst_d;
      link       <= link_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      reg_we     <= reg_we_d;
      retire     <= retire_d;
    end
  end

  // Next state plus registered strobes computed from the state being entered.
  always_comb begin
    state_d   = state_q;
    flags_d   = flags_q;
    inst_d    = inst;
    link_d    = link;
    pc_upd_c  = 1'b0;
    pc_take_c = 1'b0;

    case (state_q)
      FETCH: begin
        if (imem_req_q && bus.imem_ack) begin
          inst_d  = bus.imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        flags_d = dec_c;
        state_d = (ctrl_flags[MR] || ctrl_flags[MW]) ? MEM : WB;
      end
      MEM: begin
        if (dmem_req_q && bus.dmem_ack) state_d = WB;
      end
      WB: begin
        pc_upd_c  = 1'b1;
        pc_take_c = flags_q.wpc || flags_q.ji || (flags_q.br && cond);
        if (flags_q.spc) link_d = pc_inc_c;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // An outstanding fetch request is held until acked even if run drops.
    imem_req_d = (state_d == FETCH) && (run || imem_req_q);
    dmem_req_d = (state_d == MEM);
    dmem_we_d  = (state_d == MEM) && fl_c.mw;
    reg_we_d   = (state_d == WB) && !(fl_c.mw || fl_c.br);
    retire_d   = (state_d == WB);
  end

`ifdef INST_SEQ_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retire_cnt <= '0;
    else if (retire) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_inst_seq.sv
// Directed bench for inst_seq: instruction vector table plus reset corner sequences.
module tb_inst_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [15:0] inst;
  logic [3:0]  opcode;
  logic [15:0] ctrl_flags;
  logic        cond;
  logic [7:0]  pc_target;
  logic [7:0]  pc;
  logic [7:0]  link;
  logic        reg_we;
  logic        retire;
`ifdef INST_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  int checks = 0;
  int errors = 0;

  inst_seq_if #(.PC_W(8)) bus ();

  inst_seq #(.PC_W(8), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .bus        (bus.master),
    .inst       (inst),
    .opcode     (opcode),
    .ctrl_flags (ctrl_flags),
    .cond       (cond),
    .pc_target  (pc_target),
    .pc         (pc),
    .link       (link),
    .reg_we     (reg_we),
`ifdef INST_SEQ_RETIRE_CNT_EN
    .retire_cnt (retire_cnt),
`endif
    .retire     (retire)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] rdata;
    logic [15:0] flags;
    logic        cond;
    logic [7:0]  target;
    int          iwait;
    int          dwait;
    int          cyc;
    logic        reg_we;
    logic        mem;
    logic        we;
    logic [7:0]  npc;
    logic [7:0]  link;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Plays instruction and data memory for one instruction, starting in FETCH.
  task automatic run_vec(input vec_t v, input int idx);
    int   cyc = 0;
    int   ireq = 0;
    int   dreq = 0;
    bit   done = 0;
    bit   saw_mem = 0;
    bit   prev_iack = 0;
    logic rw = 1'b0;
    ctrl_flags = v.flags;
    cond       = v.cond;
    pc_target  = v.target;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (prev_iack) chk($sformatf("v%0d opcode", idx), 32'(opcode), 32'(v.rdata[15:12]));
      prev_iack = 0;
      if (bus.imem_req) begin
        ireq++;
        if (ireq == 1) chk($sformatf("v%0d imem_addr", idx), 32'(bus.imem_addr), 32'(v.pc));
        bus.imem_ack   = (ireq > v.iwait);
        bus.imem_rdata = v.rdata;
        prev_iack      = bus.imem_ack;
      end else begin
        bus.imem_ack = 1'b0;
      end
      if (bus.dmem_req) begin
        saw_mem = 1;
        dreq++;
        chk($sformatf("v%0d dmem_we", idx), 32'(bus.dmem_we), 32'(v.we));
        bus.dmem_ack = (dreq > v.dwait);
      end else begin
        bus.dmem_ack = 1'b0;
      end
      if (retire) begin
        done = 1;
        rw   = reg_we;
      end
    end
    chk($sformatf("v%0d retired", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d cycles", idx), 32'(cyc), 32'(v.cyc));
    chk($sformatf("v%0d reg_we", idx), 32'(rw), 32'(v.reg_we));
    chk($sformatf("v%0d mem_seen", idx), 32'(saw_mem), 32'(v.mem));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d pc", idx), 32'(pc), 32'(v.npc));
    chk($sformatf("v%0d link", idx), 32'(link), 32'(v.link));
  endtask

  initial begin
    //          pc     rdata     flags     c     tgt   iw dw cyc rw    mem   we    npc    link
    vecs[0] = '{8'h00, 16'h0123, 16'h0000, 1'b0, 8'h00, 0, 0, 3, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00};
    vecs[1] = '{8'h01, 16'h1234, 16'h0002, 1'b0, 8'h00, 0, 2, 6, 1'b1, 1'b1, 1'b0, 8'h02, 8'h00};
    vecs[2] = '{8'h02, 16'h2345, 16'h0004, 1'b0, 8'h00, 1, 0, 5, 1'b0, 1'b1, 1'b1, 8'h03, 8'h00};
    vecs[3] = '{8'h03, 16'h3000, 16'h0080, 1'b1, 8'h40, 0, 0, 3, 1'b0, 1'b0, 1'b0, 8'h40, 8'h00};
    vecs[4] = '{8'h40, 16'h4000, 16'h0080, 1'b0, 8'h10, 0, 0, 3, 1'b0, 1'b0, 1'b0, 8'h41, 8'h00};
    vecs[5] = '{8'h41, 16'h5000, 16'h0018, 1'b0, 8'hFF, 0, 0, 3, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h42};
    vecs[6] = '{8'hFF, 16'h6000, 16'h0000, 1'b0, 8'h20, 0, 0, 3, 1'b1, 1'b0, 1'b0, 8'h00, 8'h42};
    vecs[7] = '{8'h00, 16'h7000, 16'h0006, 1'b0, 8'h00, 0, 1, 5, 1'b0, 1'b1, 1'b1, 8'h01, 8'h42};
    vecs[8] = '{8'h01, 16'h8000, 16'hFF20, 1'b0, 8'h80, 0, 0, 3, 1'b1, 1'b0, 1'b0, 8'h80, 8'h42};
    vecs[9] = '{8'h80, 16'h9000, 16'h0008, 1'b1, 8'h33, 0, 0, 3, 1'b1, 1'b0, 1'b0, 8'h81, 8'h81};

    // Reset held with acks high: nothing may move.
    rst_n = 1'b0; run = 1'b1; cond = 1'b0; pc_target = '0; ctrl_flags = '0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hFFFF; bus.dmem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst pc", 32'(pc), 32'h0);
    chk("rst imem_req", 32'(bus.imem_req), 32'h0);
    chk("rst dmem_req", 32'(bus.dmem_req), 32'h0);
    chk("rst reg_we", 32'(reg_we), 32'h0);
    chk("rst retire", 32'(retire), 32'h0);
    chk("rst inst", 32'(inst), 32'h0);
    rst_n = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("rel imem_req", 32'(bus.imem_req), 32'h1);
    chk("rel imem_addr", 32'(bus.imem_addr), 32'h0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

`ifdef INST_SEQ_RETIRE_CNT_EN
    chk("retire_cnt", retire_cnt, 32'd10);
`endif

    // Reset in the middle of a stalled load.
    begin
      bit seen = 0;
      ctrl_flags = 16'h0002;
      bus.imem_rdata = 16'hA000;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        bus.imem_ack = bus.imem_req;
        if (bus.dmem_req) seen = 1;
      end
      chk("midrst dmem_req seen", 32'(seen), 32'h1);
    end
    bus.imem_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst dmem_req", 32'(bus.dmem_req), 32'h0);
    chk("midrst dmem_we", 32'(bus.dmem_we), 32'h0);
    chk("midrst pc", 32'(pc), 32'h0);
    chk("midrst inst", 32'(inst), 32'h0);
    chk("midrst link", 32'(link), 32'h0);
    bus.dmem_ack = 1'b1; bus.imem_ack = 1'b1; run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d imem_req", c), 32'(bus.imem_req), 32'h0);
      chk($sformatf("idle%0d dmem_req", c), 32'(bus.dmem_req), 32'h0);
      chk($sformatf("idle%0d inst", c), 32'(inst), 32'h0);
      chk($sformatf("idle%0d retire", c), 32'(retire), 32'h0);
    end
    run = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("refetch imem_req", 32'(bus.imem_req), 32'h1);
    chk("refetch imem_addr", 32'(bus.imem_addr), 32'h0);
    begin
      vec_t v;
      v = '{8'h00, 16'hB000, 16'h0000, 1'b0, 8'h00, 0, 0, 3, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00};
      run_vec(v, 10);
    end
`ifdef INST_SEQ_RETIRE_CNT_EN
    chk("retire_cnt after reset", retire_cnt, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_seq.md
Name: inst_seq

Overview:
- Multi-cycle instruction sequencer: the driving end of the opcode-to-control-flag decode interface.
- Fetches 16-bit instruction words from instruction memory and presents the opcode to the combinational decode ROM.
- Consumes the returned ctrl_flags to step through data-memory access, register writeback and PC update.
- Sits between the PC/instruction-memory port and the datapath; one instruction in flight.

Parameters:
- PC_W, 8, program counter / imem address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- run  input  1  sampled in FETCH; low holds the sequencer idle before the next fetch.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  PC_W  fetch address (= pc).
- imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
- imem_rdata  input  16  instruction word.
- inst  output  16  latched instruction word, to datapath.
- opcode  output  4  inst[15:12], to decode ROM.
- ctrl_flags  input  16  decode ROM control flags for opcode.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write enable (valid with dmem_req).
- dmem_ack  input  1  data access complete.
- cond  input  1  branch condition from datapath.
- pc_target  input  PC_W  jump/branch target from datapath.
- pc  output  PC_W  current program counter.
- link  output  PC_W  pc+1 captured for link writes.
- reg_we  output  1  register file write strobe, one cycle.
- retire  output  1  one-cycle pulse per completed instruction.

Behaviour:
- Reset (async, rst_n low):
  - State FETCH; pc=RESET_PC; inst=0, opcode=0, link=0.
  - imem_req, dmem_req, dmem_we, reg_we and retire all 0.
  - Requests drop immediately, not at the next edge; acks arriving after reset are ignored.
- Flag bits (package constants):
  - LD=0, MR=1, MW=2, SPC=3, WPC=4, JI=5, IMM=6, BR=7.
  - Bits 8..15 are datapath-only; the sequencer ignores them.
- States: FETCH, DECODE, MEM, WB.
- FETCH:
  - With run=1: imem_req=1, imem_addr=pc, held stable until imem_ack is sampled high.
  - On ack: inst<=imem_rdata, go to DECODE.
  - An ack in the first request cycle is legal, giving a 1-cycle fetch.
  - With run=0: no request, stay in FETCH.
- DECODE:
  - opcode is valid and stable from this cycle until the next fetch completes; ctrl_flags is sampled here.
  - MR|MW goes to MEM; otherwise go to WB.
- MEM:
  - dmem_req=1, dmem_we=ctrl_flags[MW], held until dmem_ack.
  - On ack, go to WB.
  - If both MR and MW are set, MW wins (dmem_we=1).
- WB (one cycle):
  - reg_we=1 unless MW or BR is set.
  - If SPC: link<=pc+1.
  - Next pc:
    - pc_target if WPC or JI;
    - pc_target if BR and cond=1;
    - otherwise pc+1, modulo 2^PC_W (wrap from all-ones to 0).
  - retire=1; next state FETCH.
- Latency: 3 cycles minimum per non-memory instruction, 4 minimum with a memory access; each wait cycle adds 1.
- Acks received while the matching req is low are ignored.
- ctrl_flags is not sampled outside DECODE, so decode glitches elsewhere are harmless.

Optional Feature:
- Macro INST_SEQ_RETIRE_CNT_EN.
- Defined: adds output retire_cnt (32 bits).
  - Reset to 0; increments on every retire pulse; wraps at 2^32.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package scd_pkg holds:
  - flag bit index constants (LD..BR);
  - state enum (FETCH, DECODE, MEM, WB);
  - INST_W=16;
  - opcode field position constants (15:12).
- One natural sub-module, inst_seq_pc: the pc register plus next-pc select (pc+1 / pc_target, wrap).
- The FSM and handshake logic stay in inst_seq.

Test Plan:
- Reset: hold rst_n=0 with imem_ack=1 -> pc=0, imem_req=0, reg_we=0. Release with run=1 -> imem_req=1, imem_addr=0 next cycle.
- Zero-wait ALU op: rdata=16'h0123, flags=0, immediate acks -> opcode=0 in DECODE; reg_we=1 and retire=1 at cycle 3; pc=1.
- Load with 2 wait cycles: flags=0x0002, dmem_ack 3rd cycle of MEM -> dmem_we=0, reg_we=1 one cycle after ack, total 6 cycles.
- Store: flags=0x0004 -> dmem_we=1 throughout MEM, reg_we=0 in WB, pc+1.
- Branch: flags=0x0080, pc_target=0x40. cond=1 -> pc=0x40, reg_we=0; cond=0 -> pc=pc+1. Also pc=0xFF, flags=0 -> pc wraps to 0x00.
- Mid-operation reset: assert rst_n=0 while dmem_req=1 -> dmem_req=0 immediately; late dmem_ack ignored; refetch from RESET_PC.
